// File: rtl/ram_stream_reader.sv
// Streams a contiguous, wrapping range of a 1-cycle-latency RAM out as valid/ready words.
// A 2-entry skid buffer plus one in-flight read gives full throughput under backpressure.
module ram_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  n_rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   length_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ram_re_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   input  logic [DATA_WIDTH-1:0] ram_data_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  m_last_o
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [ADDR_WIDTH:0]     remaining_reg;
   logic                    inflight_reg;
   logic                    inflight_last_reg;
   logic [1:0]              count_reg;
   logic                    rd_ptr_reg;
   logic                    wr_ptr_reg;
   logic [DATA_WIDTH-1:0]   buf_data_reg [2];
   logic [1:0]              buf_last_reg;

   logic pop;
   logic push;
   logic room;
   logic issue;
   logic load;

   assign pop  = m_valid_o & m_ready_i;
   assign push = inflight_reg;
   // Occupancy counts the read already in flight; a same-cycle pop frees a slot.
   assign room = ({1'b0, count_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop});

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      load       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               if (length_i != '0) begin
                  load       = 1'b1;
                  state_next = READ;
               end else begin
                  state_next = DONE;
               end
            end
         end
         READ: begin
            if (remaining_reg != '0 && room) begin
               issue = 1'b1;
               if (remaining_reg == REM_ONE) state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Leave as soon as the final word pops so done_o follows it directly.
            if (!inflight_reg && (count_reg == 2'd0 || (count_reg == 2'd1 && pop)))
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign ram_re_o   = issue;
   assign ram_addr_o = addr_reg;
   assign busy_o     = (state_reg == READ) || (state_reg == DRAIN);
   assign done_o     = (state_reg == DONE);
   assign m_valid_o  = (count_reg != 2'd0);
   assign m_data_o   = buf_data_reg[rd_ptr_reg];
   assign m_last_o   = buf_last_reg[rd_ptr_reg] & m_valid_o;

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         addr_reg          <= '0;
         remaining_reg     <= '0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
         count_reg         <= 2'd0;
         rd_ptr_reg        <= 1'b0;
         wr_ptr_reg        <= 1'b0;
      end else begin
         if (load) begin
            addr_reg      <= base_addr_i;
            remaining_reg <= length_i;
         end else if (issue) begin
            addr_reg      <= (addr_reg == ADDR_LAST) ? '0 : addr_reg + ADDR_WIDTH'(1);
            remaining_reg <= remaining_reg - REM_ONE;
         end
         inflight_reg      <= issue;
         inflight_last_reg <= issue && (remaining_reg == REM_ONE);
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk_i or negedge n_rst_i) begin
         if (!n_rst_i) begin
            buf_data_reg[gi] <= '0;
            buf_last_reg[gi] <= 1'b0;
         end else if (push && wr_ptr_reg == 1'(gi)) begin
            buf_data_reg[gi] <= ram_data_i;
            buf_last_reg[gi] <= inflight_last_reg;
         end
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader: expected words/addresses come from the
// transfer definition (base, length, wrap), checked against the stream as it pops.
module tb_ram_stream_reader;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk_i = 1'b0;
   logic          n_rst_i;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [AW:0]   length_i;
   logic          busy_o;
   logic          done_o;
   logic          ram_re_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_data_i;
   logic [DW-1:0] m_data_o;
   logic          m_valid_o;
   logic          m_ready_i;
   logic          m_last_o;

   logic [DW-1:0] ram_mem [DEPTH];
   logic [DW-1:0] ram_q;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW:0] exp_q [$];
   int          exp_addr_q [$];

   ram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk_i       (clk_i),
      .n_rst_i     (n_rst_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .length_i    (length_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ram_re_o    (ram_re_o),
      .ram_addr_o  (ram_addr_o),
      .ram_data_i  (ram_data_i),
      .m_data_o    (m_data_o),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .m_last_o    (m_last_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (ram_re_o) ram_q <= ram_mem[ram_addr_o];
   end
   assign ram_data_i = ram_q;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_busy"},  32'(busy_o),     32'd0);
      check_value({tag, "_done"},  32'(done_o),     32'd0);
      check_value({tag, "_re"},    32'(ram_re_o),   32'd0);
      check_value({tag, "_addr"},  32'(ram_addr_o), 32'd0);
      check_value({tag, "_valid"}, 32'(m_valid_o),  32'd0);
      check_value({tag, "_last"},  32'(m_last_o),   32'd0);
      check_value({tag, "_data"},  32'(m_data_o),   32'd0);
   endtask

   // mode 0: sink always ready; mode 1: 5-cycle stall after first valid, then 50% ready.
   task automatic run_xfer(input int base, input int len, input int mode, input bit poke_start);
      int          lastpop_c = 0;
      int          first_valid_c = 0;
      int          issued = 0;
      int          popped = 0;
      int          occ;
      int          a;
      bit          prev_re = 0;
      bit          prev_stall = 0;
      bit          re, pop, finished, exp_done;
      logic [DW-1:0] prev_data = '0;
      logic [DW:0] w;
      logic        is_last;

      exp_q.delete();
      exp_addr_q.delete();
      for (int i = 0; i < len; i++) begin
         a = (base + i) % DEPTH;
         is_last = (i == len - 1);
         exp_addr_q.push_back(a);
         exp_q.push_back({is_last, ram_mem[a]});
      end

      start_i     = 1'b1;
      base_addr_i = AW'(base);
      length_i    = (AW+1)'(len);
      m_ready_i   = 1'b1;
      @(negedge clk_i);
      check_value("start_cycle_re", 32'(ram_re_o), 32'd0);
      @(posedge clk_i); #1;

      finished = 0;
      for (int c = 1; c <= 400 && !finished; c++) begin
         start_i = poke_start && (c == 3);
         if (start_i) begin
            base_addr_i = AW'(9);
            length_i    = (AW+1)'(3);
         end
         if (m_valid_o && first_valid_c == 0) first_valid_c = c;
         if (mode == 0) m_ready_i = 1'b1;
         else if (first_valid_c != 0 && c < first_valid_c + 5) m_ready_i = 1'b0;
         else m_ready_i = 1'($urandom_range(0, 1));

         @(negedge clk_i);
         re  = ram_re_o;
         pop = m_valid_o && m_ready_i;

         if (c == 1) check_value("first_re", 32'(re), 32'(len > 0));
         if (c == 2) check_value("valid_c2", 32'(m_valid_o), 32'd0);
         if (c == 3) check_value("valid_c3", 32'(m_valid_o), 32'(len > 0));
         if (mode == 0 && len > 0 && c >= 3 && c <= 2 + len)
            check_value("throughput", 32'(m_valid_o), 32'd1);
         check_value("busy", 32'(busy_o), 32'(len > 0 && popped < len));
         exp_done = (len == 0 && c == 1) || (lastpop_c != 0 && c == lastpop_c + 1);
         check_value("done", 32'(done_o), 32'(exp_done));
         if (!m_valid_o) check_value("last_idle", 32'(m_last_o), 32'd0);
         if (prev_stall) begin
            check_value("stall_valid", 32'(m_valid_o), 32'd1);
            check_value("stall_data", 32'(m_data_o), 32'(prev_data));
         end
         occ = issued - popped - int'(prev_re);
         if (occ == 2 && !pop) check_value("re_when_full", 32'(re), 32'd0);
         check_value("occupancy", 32'((issued + int'(re) - popped - int'(pop)) <= 2), 32'd1);

         if (re) begin
            if (exp_addr_q.size() == 0) check_value("extra_read", 32'd1, 32'd0);
            else begin
               a = exp_addr_q.pop_front();
               check_value("ram_addr", 32'(ram_addr_o), 32'(a));
            end
         end
         if (pop) begin
            if (exp_q.size() == 0) check_value("extra_word", 32'd1, 32'd0);
            else begin
               w = exp_q.pop_front();
               check_value("m_data", 32'(m_data_o), 32'(w[DW-1:0]));
               check_value("m_last", 32'(m_last_o), 32'(w[DW]));
            end
            popped++;
            if (popped == len) lastpop_c = c;
         end
         issued    += int'(re);
         prev_re    = re;
         prev_stall = m_valid_o && !m_ready_i;
         prev_data  = m_data_o;
         finished   = exp_done;
         @(posedge clk_i); #1;
      end
      if (!finished) check_value("timeout", 32'd0, 32'd1);

      start_i   = 1'b0;
      m_ready_i = 1'b1;
      @(negedge clk_i);
      check_value("after_done", 32'(done_o), 32'd0);
      check_value("after_busy", 32'(busy_o), 32'd0);
      check_value("after_valid", 32'(m_valid_o), 32'd0);
      check_value("words_left", 32'(exp_q.size()), 32'd0);
      check_value("reads_left", 32'(exp_addr_q.size()), 32'd0);
      $display("xfer base=%0d len=%0d mode=%0d poke=%0d popped=%0d", base, len, mode, poke_start, popped);
      @(posedge clk_i); #1;
   endtask

   task automatic reset_mid_transfer();
      int popped = 0;
      start_i     = 1'b1;
      base_addr_i = AW'(0);
      length_i    = (AW+1)'(6);
      m_ready_i   = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int c = 0; c < 20 && popped < 2; c++) begin
         @(negedge clk_i);
         if (m_valid_o && m_ready_i) begin
            check_value("pre_reset_data", 32'(m_data_o), 32'(8'h10 + popped));
            popped++;
         end
         @(posedge clk_i); #1;
      end
      check_value("pre_reset_pops", 32'(popped), 32'd2);
      n_rst_i = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk_i);
      check_reset_outputs("midrst_hold");
      @(posedge clk_i); #1;
      n_rst_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         check_value("post_rst_done", 32'(done_o), 32'd0);
         check_value("post_rst_valid", 32'(m_valid_o), 32'd0);
         check_value("post_rst_re", 32'(ram_re_o), 32'd0);
         @(posedge clk_i); #1;
      end
      $display("reset mid-transfer after %0d pops", popped);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = 8'(8'h10 + i);
      ram_q       = '0;
      n_rst_i     = 1'b0;
      start_i     = 1'b0;
      base_addr_i = '0;
      length_i    = '0;
      m_ready_i   = 1'b0;
      @(posedge clk_i); @(posedge clk_i); #1;
      check_reset_outputs("reset");
      n_rst_i = 1'b1;
      @(posedge clk_i); #1;

      run_xfer(2, 4, 0, 0);
      run_xfer(14, 4, 0, 0);
      run_xfer(0, 8, 1, 0);
      run_xfer(0, 0, 0, 0);
      run_xfer(5, 16, 0, 0);
      run_xfer(0, 6, 0, 1);
      reset_mid_transfer();
      run_xfer(3, 2, 0, 0);
      for (int k = 0; k < 10; k++)
         run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                  int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
